// File: rtl/sram_uart_ctrl.sv
// Memory/UART access controller: serves one data request at a time over two async SRAM banks
// and a UART that shares the sram1 data bus, while sram2 streams instruction fetches when idle.
module sram_uart_ctrl #(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 18,
    parameter logic [ADDR_W-1:0] SPLIT_ADDR     = 'h8000,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = 'hBF00,
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = 'hBF01,
    parameter int                WR_CYCLES      = 2
) (
    input  logic              i_clk_50MHz,
    input  logic              i_rst,
    input  logic              i_req_en,
    input  logic              i_req_op,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic [DATA_W-1:0] o_req_rdata,
    output logic              o_req_done,
    output logic              o_ram_pause,
    input  logic [ADDR_W-3:0] i_pc,
    output logic [DATA_W-1:0] o_inst,
    output logic              o_inst_valid,
    inout  wire  [DATA_W-1:0] io_sram1_data,
    output logic [ADDR_W-1:0] o_sram1_addr,
    output logic              o_sram1_en,
    output logic              o_sram1_oe,
    output logic              o_sram1_we,
    inout  wire  [DATA_W-1:0] io_sram2_data,
    output logic [ADDR_W-1:0] o_sram2_addr,
    output logic              o_sram2_en,
    output logic              o_sram2_oe,
    output logic              o_sram2_we,
    output logic              o_rdn,
    output logic              o_wrn,
    input  logic              i_data_ready,
    input  logic              i_tbre,
    input  logic              i_tsre
);

    localparam int CNT_W = $clog2(WR_CYCLES + 2);

    typedef enum logic [2:0] {
        IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, U_WAIT, U_STROBE, DONE
    } state_t;

    typedef enum logic [1:0] {T_SRAM1, T_SRAM2, T_STAT, T_UART} target_t;

    state_t              r_state;
    state_t              w_next_state;
    target_t             r_tgt;
    target_t             w_tgt;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_op;
    logic                r_fetch_en;
    logic                w_drive1;
    logic                w_drive2;
    logic                w_bank_access;
    logic                w_uart_ready;

    // UART addresses win over the bank split because they sit inside the sram1 range.
    always_comb begin
        if (i_req_addr == UART_DATA_ADDR)      w_tgt = T_UART;
        else if (i_req_addr == UART_STAT_ADDR) w_tgt = T_STAT;
        else if (i_req_addr < SPLIT_ADDR)      w_tgt = T_SRAM2;
        else                                   w_tgt = T_SRAM1;
    end

    assign w_uart_ready = r_op ? (i_tbre & i_tsre) : i_data_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_req_en) begin
                    case (w_tgt)
                        T_UART:  w_next_state = U_WAIT;
                        T_STAT:  w_next_state = RD;
                        default: w_next_state = i_req_op ? WR_SETUP : RD;
                    endcase
                end
            end
            RD:       w_next_state = DONE;
            WR_SETUP: w_next_state = WR_PULSE;
            WR_PULSE: if (r_cnt == CNT_W'(WR_CYCLES - 1)) w_next_state = WR_HOLD;
            WR_HOLD:  w_next_state = DONE;
            U_WAIT:   if (w_uart_ready) w_next_state = U_STROBE;
            U_STROBE: if (r_cnt == CNT_W'(1)) w_next_state = DONE;
            DONE:     w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_50MHz or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_tgt       <= T_SRAM1;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_op        <= 1'b0;
            r_fetch_en  <= 1'b0;
            o_req_rdata <= '0;
        end else begin
            r_state    <= w_next_state;
            r_fetch_en <= 1'b1;
            if (r_state == IDLE && i_req_en) begin
                r_tgt   <= w_tgt;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_op    <= i_req_op;
            end
            if ((r_state == WR_PULSE || r_state == U_STROBE) && w_next_state == r_state)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (r_state == RD && !r_op) begin
                case (r_tgt)
                    T_SRAM1: o_req_rdata <= io_sram1_data;
                    T_SRAM2: o_req_rdata <= io_sram2_data;
                    default: o_req_rdata <= {{(DATA_W-2){1'b0}}, i_data_ready, i_tbre & i_tsre};
                endcase
            end
            // The UART only returns a byte on the low lanes of the shared bus.
            if (r_state == U_STROBE && !r_op && w_next_state == DONE)
                o_req_rdata <= {{(DATA_W-8){1'b0}}, io_sram1_data[7:0]};
        end
    end

    assign w_bank_access = (r_state == RD || r_state == WR_SETUP || r_state == WR_PULSE ||
                            r_state == WR_HOLD) && (r_tgt == T_SRAM1 || r_tgt == T_SRAM2);

    always_comb begin
        o_sram1_addr = '0;
        o_sram1_en   = 1'b1;
        o_sram1_oe   = 1'b1;
        o_sram1_we   = 1'b1;
        o_sram2_addr = '0;
        o_sram2_en   = 1'b1;
        o_sram2_oe   = 1'b1;
        o_sram2_we   = 1'b1;
        o_rdn        = 1'b1;
        o_wrn        = 1'b1;
        o_inst_valid = 1'b0;
        w_drive1     = 1'b0;
        w_drive2     = 1'b0;
        if (r_fetch_en && !(w_bank_access && r_tgt == T_SRAM2)) begin
            o_sram2_addr = {2'b00, i_pc};
            o_sram2_en   = 1'b0;
            o_sram2_oe   = 1'b0;
            o_inst_valid = 1'b1;
        end
        if (w_bank_access && r_tgt == T_SRAM1) begin
            o_sram1_addr = r_addr;
            o_sram1_en   = 1'b0;
            o_sram1_oe   = (r_state != RD);
            o_sram1_we   = (r_state != WR_PULSE);
            w_drive1     = (r_state != RD);
        end
        if (w_bank_access && r_tgt == T_SRAM2) begin
            o_sram2_addr = r_addr;
            o_sram2_en   = 1'b0;
            o_sram2_oe   = (r_state != RD);
            o_sram2_we   = (r_state != WR_PULSE);
            w_drive2     = (r_state != RD);
        end
        if (r_state == U_STROBE) begin
            o_rdn    = r_op;
            o_wrn    = !r_op;
            w_drive1 = r_op;
        end
    end

    assign o_req_done  = (r_state == DONE);
    assign o_ram_pause = i_rst & ((r_state == IDLE && i_req_en) ||
                                  (r_state != IDLE && r_state != DONE));
    assign o_inst      = io_sram2_data;

    assign io_sram1_data = w_drive1 ? r_wdata : {DATA_W{1'bz}};
    assign io_sram2_data = w_drive2 ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_uart_ctrl.sv
// Self-checking bench for sram_uart_ctrl: behavioural SRAM/UART environment plus a
// request-level reference model (expected data, latencies and strobe widths).
module tb_sram_uart_ctrl;

   localparam int WR_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rstN;
   logic        reqEn;
   logic        reqOp;
   logic [17:0] reqAddr;
   logic [15:0] reqWdata;
   logic [15:0] reqRdata;
   logic        reqDone;
   logic        ramPause;
   logic [15:0] pc;
   logic [15:0] inst;
   logic        instValid;
   wire  [15:0] sram1Data;
   wire  [15:0] sram2Data;
   logic [17:0] sram1Addr;
   logic [17:0] sram2Addr;
   logic        sram1En, sram1Oe, sram1We;
   logic        sram2En, sram2Oe, sram2We;
   logic        rdn, wrn;
   logic        dataReady, tbre, tsre;
   logic [7:0]  uartByte;

   int vectors = 0;
   int miscompares = 0;

   // Environment memories (what the chips hold) and reference memories (what they should hold).
   logic [15:0] mem1 [4096];
   logic [15:0] mem2 [4096];
   logic [15:0] refMem1 [4096];
   logic [15:0] refMem2 [4096];

   logic [17:0] pool1 [4] = '{18'h08000, 18'h09000, 18'h3FFFF, 18'h0BF02};
   logic [17:0] pool2 [4] = '{18'h00000, 18'h00100, 18'h01234, 18'h07FFF};

   always #10 clk = ~clk;

   sram_uart_ctrl #(.WR_CYCLES(WR_CYCLES)) dut (
      .i_clk_50MHz(clk), .i_rst(rstN),
      .i_req_en(reqEn), .i_req_op(reqOp), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
      .o_req_rdata(reqRdata), .o_req_done(reqDone), .o_ram_pause(ramPause),
      .i_pc(pc), .o_inst(inst), .o_inst_valid(instValid),
      .io_sram1_data(sram1Data), .o_sram1_addr(sram1Addr),
      .o_sram1_en(sram1En), .o_sram1_oe(sram1Oe), .o_sram1_we(sram1We),
      .io_sram2_data(sram2Data), .o_sram2_addr(sram2Addr),
      .o_sram2_en(sram2En), .o_sram2_oe(sram2Oe), .o_sram2_we(sram2We),
      .o_rdn(rdn), .o_wrn(wrn),
      .i_data_ready(dataReady), .i_tbre(tbre), .i_tsre(tsre)
   );

   // SRAM chips drive their bus on an enabled read; the UART drives the low byte of sram1's bus on rdn.
   assign sram1Data = (!sram1En && !sram1Oe && sram1We) ? mem1[sram1Addr[11:0]] :
                      (!rdn ? {8'h00, uartByte} : 16'hzzzz);
   assign sram2Data = (!sram2En && !sram2Oe && sram2We) ? mem2[sram2Addr[11:0]] : 16'hzzzz;

   // Chips commit a write on the rising edge of WE while selected.
   always @(posedge sram1We) if (!sram1En && rstN) mem1[sram1Addr[11:0]] = sram1Data;
   always @(posedge sram2We) if (!sram2En && rstN) mem2[sram2Addr[11:0]] = sram2Data;

   // One comparison: counts the vector, flags and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present a request on the request port.
   task automatic applyStimulus(input logic op, input logic [17:0] addr, input logic [15:0] wdata);
      reqEn    = 1'b1;
      reqOp    = op;
      reqAddr  = addr;
      reqWdata = wdata;
   endtask

   // Drive one full request and check it against the request-level model.
   // statBits = {data_ready, tbre, tsre} seen by a status read; waitCycles = UART not-ready cycles.
   task automatic runRequest(input logic op, input logic [17:0] addr, input logic [15:0] wdata,
                             input logic [15:0] pcVal, input int waitCycles,
                             input logic [2:0] statBits, input logic [7:0] byteVal);
      bit          isUart, isStat, isBank, isBank2;
      int          expLat, doneAt, weLow, rdnLow, wrnLow;
      logic [15:0] expRdata;
      isUart  = (addr == 18'h0BF00);
      isStat  = (addr == 18'h0BF01);
      isBank  = !isUart && !isStat;
      isBank2 = isBank && (addr < 18'h08000);
      expLat  = isUart ? waitCycles + 4 : ((isBank && op) ? WR_CYCLES + 3 : 2);
      doneAt  = -1;
      weLow   = 0;
      rdnLow  = 0;
      wrnLow  = 0;
      pc       = pcVal;
      uartByte = byteVal;
      if (isUart) begin
         dataReady = op;
         tbre      = !op;
         tsre      = !op;
      end else begin
         {dataReady, tbre, tsre} = statBits;
      end
      if (isStat)      expRdata = {14'b0, statBits[2], statBits[1] & statBits[0]};
      else if (isUart) expRdata = {8'h00, byteVal};
      else if (isBank2) expRdata = refMem2[addr[11:0]];
      else             expRdata = refMem1[addr[11:0]];
      applyStimulus(op, addr, wdata);
      #1 checkOutput("pause_accept", ramPause, 1'b1);
      for (int k = 1; k <= expLat + 30; k++) begin
         @(negedge clk);
         if (reqDone) begin
            doneAt = k;
            break;
         end
         checkOutput("pause_busy", ramPause, 1'b1);
         if (isBank2) checkOutput("iv_owned", instValid, 1'b0);
         else begin
            checkOutput("iv_fetch", instValid, 1'b1);
            checkOutput("fetch_addr", sram2Addr, {2'b00, pcVal});
         end
         if (k == 1 && isBank) begin
            checkOutput("bank_addr", isBank2 ? sram2Addr : sram1Addr, addr);
            checkOutput("bank_ce", isBank2 ? sram2En : sram1En, 1'b0);
         end
         if (isStat || isUart) checkOutput("s1_ctrl_idle", {sram1En, sram1Oe, sram1We}, 3'b111);
         if (isBank && (isBank2 ? !sram2We : !sram1We)) weLow++;
         if (!rdn) rdnLow++;
         if (!wrn) begin
            wrnLow++;
            checkOutput("uart_wdata", sram1Data, wdata);
         end
         if (isUart) begin
            if (k > waitCycles) begin
               if (op) {tbre, tsre} = 2'b11;
               else dataReady = 1'b1;
            end else if (op) begin
               case ($urandom_range(0, 2))
                  0: {tbre, tsre} = 2'b00;
                  1: {tbre, tsre} = 2'b01;
                  default: {tbre, tsre} = 2'b10;
               endcase
               dataReady = 1'b1;
            end
         end
      end
      reqEn = 1'b0;
      if (op && isBank) begin
         if (isBank2) refMem2[addr[11:0]] = wdata;
         else refMem1[addr[11:0]] = wdata;
      end
      checkOutput("latency", doneAt, expLat);
      checkOutput("pause_done", ramPause, 1'b0);
      checkOutput("iv_done", instValid, 1'b1);
      checkOutput("fetch_resume", sram2Addr, {2'b00, pcVal});
      checkOutput("inst_data", inst, refMem2[pcVal[11:0]]);
      checkOutput("we_width", weLow, (isBank && op) ? WR_CYCLES : 0);
      checkOutput("rdn_width", rdnLow, (isUart && !op) ? 2 : 0);
      checkOutput("wrn_width", wrnLow, (isUart && op) ? 2 : 0);
      if (!op) checkOutput("rdata", reqRdata, expRdata);
      @(negedge clk);
      checkOutput("done_pulse", reqDone, 1'b0);
      checkOutput("pause_idle", ramPause, 1'b0);
   endtask

   // Everything that reset must force, checked without waiting for a clock edge.
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_s1ctl"}, {sram1En, sram1Oe, sram1We}, 3'b111);
      checkOutput({tag, "_s2ctl"}, {sram2En, sram2Oe, sram2We}, 3'b111);
      checkOutput({tag, "_uartctl"}, {rdn, wrn}, 2'b11);
      checkOutput({tag, "_addr"}, {sram1Addr, sram2Addr}, 36'h0);
      checkOutput({tag, "_bus1"}, sram1Data, 16'hzzzz);
      checkOutput({tag, "_bus2"}, sram2Data, 16'hzzzz);
      checkOutput({tag, "_flags"}, {reqDone, ramPause, instValid}, 3'b000);
      checkOutput({tag, "_rdata"}, reqRdata, 16'h0000);
   endtask

   initial begin
      int kind;
      for (int i = 0; i < 4096; i++) begin
         mem1[i]    = 16'h1000 ^ 16'(i * 7);
         mem2[i]    = 16'h8000 ^ 16'(i * 13);
         refMem1[i] = mem1[i];
         refMem2[i] = mem2[i];
      end
      rstN = 1'b0;
      reqEn = 1'b1;
      reqOp = 1'b0;
      reqAddr = 18'h00100;
      reqWdata = 16'h0000;
      pc = 16'h0040;
      dataReady = 1'b0;
      tbre = 1'b0;
      tsre = 1'b0;
      uartByte = 8'h00;

      // Power-on reset, with a request already asserted that must not leak through.
      #5 checkResetState("por");
      reqEn = 1'b0;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      #1 checkOutput("first_fetch_wait", instValid, 1'b0);
      @(negedge clk);
      checkOutput("first_fetch", instValid, 1'b1);
      checkOutput("first_fetch_addr", sram2Addr, 18'h00040);
      checkOutput("first_fetch_inst", inst, refMem2[12'h040]);

      // Directed scenarios.
      runRequest(1'b1, 18'h09000, 16'hA5A5, 16'h0040, 0, 3'b000, 8'h00);
      runRequest(1'b0, 18'h00100, 16'h0000, 16'h0040, 0, 3'b000, 8'h00);
      runRequest(1'b0, 18'h0BF00, 16'h0000, 16'h0040, 10, 3'b000, 8'h41);
      runRequest(1'b0, 18'h0BF01, 16'h0000, 16'h0040, 0, 3'b110, 8'h00);
      runRequest(1'b0, 18'h09000, 16'h0000, 16'h0041, 0, 3'b000, 8'h00);
      runRequest(1'b1, 18'h0BF00, 16'h5A3C, 16'h0042, 3, 3'b000, 8'h00);
      runRequest(1'b1, 18'h07FFF, 16'hBEEF, 16'h0043, 0, 3'b000, 8'h00);
      runRequest(1'b0, 18'h07FFF, 16'h0000, 16'h0044, 0, 3'b000, 8'h00);

      // Randomized traffic over bank pools, status and UART.
      for (int n = 0; n < 30; n++) begin
         kind = int'($urandom_range(0, 6));
         case (kind)
            0: runRequest(1'b0, pool1[$urandom_range(0, 3)], 16'h0, 16'($urandom), 0, 3'b000, 8'h00);
            1: runRequest(1'b1, pool1[$urandom_range(0, 3)], 16'($urandom), 16'($urandom), 0, 3'b000, 8'h00);
            2: runRequest(1'b0, pool2[$urandom_range(0, 3)], 16'h0, 16'($urandom), 0, 3'b000, 8'h00);
            3: runRequest(1'b1, pool2[$urandom_range(0, 3)], 16'($urandom), 16'($urandom), 0, 3'b000, 8'h00);
            4: runRequest(1'b0, 18'h0BF01, 16'h0, 16'($urandom), 0, 3'($urandom), 8'h00);
            5: runRequest(1'b0, 18'h0BF00, 16'h0, 16'($urandom), int'($urandom_range(0, 5)), 3'b000, 8'($urandom));
            default: runRequest(1'b1, 18'h0BF00, 16'($urandom), 16'($urandom), int'($urandom_range(0, 5)), 3'b000, 8'h00);
         endcase
      end

      // Reset in the middle of a WE pulse must release the bus and strobes at once.
      pc = 16'h0040;
      applyStimulus(1'b1, 18'h09ABC, 16'h1357);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_pre_we", sram1We, 1'b0);
      checkOutput("rst_pre_bus", sram1Data, 16'h1357);
      rstN = 1'b0;
      reqEn = 1'b0;
      #1 checkResetState("midwr");
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      #1 checkOutput("rel_fetch_wait", instValid, 1'b0);
      checkOutput("rel_pause", ramPause, 1'b0);
      @(negedge clk);
      checkOutput("rel_fetch", instValid, 1'b1);
      runRequest(1'b0, 18'h01234, 16'h0, 16'h0040, 0, 3'b000, 8'h00);
      runRequest(1'b0, 18'h09000, 16'h0, 16'h0045, 0, 3'b000, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sram_uart_ctrl.md
SRAM_UART_CTRL -- requirements
Module: sram_uart_ctrl

Interface
REQ-001 Parameter DATA_W, 16, width of data, instruction and SRAM buses.
REQ-002 Parameter ADDR_W, 18, width of request and SRAM address.
REQ-003 Parameter SPLIT_ADDR, 18'h8000, addresses below go to sram2 (shared with fetch), others to sram1.
REQ-004 Parameter UART_DATA_ADDR, 18'hBF00, UART data port address.
REQ-005 Parameter UART_STAT_ADDR, 18'hBF01, UART status address.
REQ-006 Parameter WR_CYCLES, 2, width of the WE-low pulse in clocks, minimum 1.
REQ-007 clk_50MHz  in  1  single system clock, rising edge active.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 req_en / req_op  in  1 / 1  data request valid / 0=read, 1=write.
REQ-010 req_addr / req_wdata  in  ADDR_W / DATA_W  request address / write data.
REQ-011 req_rdata  out  DATA_W  registered read result.
REQ-012 req_done  out  1  one-cycle completion pulse.
REQ-013 ram_pause  out  1  pipeline stall request.
REQ-014 pc  in  ADDR_W-2  fetch address; inst  out  DATA_W  fetched word; inst_valid  out  1.
REQ-015 sramN_data  inout  DATA_W  SRAM data bus, N=1,2.
REQ-016 sramN_addr  out  ADDR_W  SRAM address, N=1,2.
REQ-017 sramN_en / sramN_oe / sramN_we  out  1  active-low CE/OE/WE, N=1,2.
REQ-018 rdn / wrn  out  1  active-low UART read/write strobes.
REQ-019 data_ready / tbre / tsre  in  1  UART receive-ready, transmit-buffer-empty, shift-register-empty.

Function
REQ-020 Decode SHALL be: UART_DATA_ADDR -> UART, UART_STAT_ADDR -> status, < SPLIT_ADDR -> sram2, otherwise sram1; UART addresses take priority.
REQ-021 FSM states SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, U_WAIT, U_STROBE, DONE.
REQ-022 Requests SHALL be accepted only at a rising edge in IDLE with req_en=1; inputs are held stable by requester until req_done; req_en in other states is ignored.
REQ-023 SRAM read: IDLE -> RD (CE=OE=0, WE=1, addr driven) -> DONE; req_rdata latched at end of RD; req_done=1 in DONE; DONE -> IDLE.
REQ-024 SRAM write: WR_SETUP 1 cycle (CE=0, OE=1, WE=1, data driven), WR_PULSE WR_CYCLES cycles (WE=0), WR_HOLD 1 cycle (WE=1, data still driven), then DONE.
REQ-025 sramN_data SHALL be driven only in WR_SETUP/WR_PULSE/WR_HOLD of that bank; high-Z otherwise.
REQ-026 Status read: RD path, no SRAM strobes, req_rdata = {zeros, data_ready, tbre&tsre}.
REQ-027 UART read: U_WAIT until data_ready=1, U_STROBE 2 cycles rdn=0, data latched from sram1_data at end of 2nd cycle, then DONE.
REQ-028 UART write: U_WAIT until tbre&tsre=1, U_STROBE 2 cycles wrn=0 with req_wdata on sram1_data, then DONE; sram1 CE/OE/WE stay 1 throughout UART access.
REQ-029 ram_pause SHALL be combinationally 1 from req_en acceptance condition in IDLE through the cycle before DONE; 0 in DONE and IDLE without request.
REQ-030 When sram2 is not owned by a data access, sram2 SHALL read with addr={2'b00,pc}, inst=sram2_data, inst_valid=1; otherwise inst_valid=0.
REQ-031 Write latency SHALL be WR_CYCLES+3 cycles accept-to-req_done; SRAM/status read 2; UART access wait time + 3.

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE, all CE/OE/WE/rdn/wrn=1, sramN_addr=0, buses high-Z, req_rdata=0, req_done=0, ram_pause=0, inst_valid=0, including mid-write (WE released immediately).
REQ-033 After rst rises, first fetch SHALL start at the next rising edge.

Verification
REQ-034 Write 16'hA5A5 to 18'h9000, WR_CYCLES=2 -> sram1_we low exactly 2 cycles, req_done at cycle 5, sram2 fetch undisturbed.
REQ-035 Read 18'h0100 while fetching pc=0x0040 -> ram_pause=1 and inst_valid=0 for 1 cycle, sram2_addr=0x0100, req_done at cycle 2, fetch resumes at 0x0040.
REQ-036 UART read with data_ready low for 10 cycles then high, line=8'h41 -> rdn low 2 cycles after rise, req_rdata=16'h0041.
REQ-037 Status read with data_ready=1, tbre=1, tsre=0 -> req_rdata=16'h0002.
REQ-038 Assert rst in WR_PULSE -> sram1_we=1 and bus high-Z without clock edge; FSM IDLE after release.
